add_seq8: RTL and testbench

Multi-byte adder/subtractor controller that time-multiplexes a single add8 instance (ports a, b, ci, co, s) over NBYTES cycles, least significant byte first. It latches wide operands on a start handshake, sequences the byte slices through add8 with a registered carry chain, and presents the sum, carry-out and signed overflow with a one-cycle done pulse. It sits between a requesting datapath and the shared 8-bit adder and is the only driver of that add8.

---
 rtl/add_seq8.sv | 81 ++++++++
 tb/tb_add_seq8.sv | 133 +++++++++++++
 2 files changed

// File: rtl/add_seq8.sv
// add_seq8: multi-byte add/subtract sequenced LSB-first through one shared 8-bit adder.
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
endmodule

module add_seq8 #(
  parameter int NBYTES = 4,
  parameter int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ovf
);
  localparam int IW = $clog2(NBYTES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    state;
  logic [W-1:0]  areg, beff;
  logic [IW-1:0] idx;
  logic          carry, c8, last, accept;
  logic [IW+2:0] off;
  logic [7:0]    sum;
  assign off    = {idx, 3'b000};
  assign last   = idx == IW'(NBYTES - 1);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign accept = start && (state == IDLE || state == DONE);
  add8 u_add8 (
    .a  (areg[off +: 8]),
    .b  (beff[off +: 8]),
    .ci (carry),
    .s  (sum),
    .co (c8)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      beff  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      areg  <= a;
      beff  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : ci;
      idx   <= '0;
      s     <= '0;
      state <= RUN;
    end else if (state == RUN) begin
      s[off +: 8] <= sum;
      carry       <= c8;
      idx         <= last ? idx : idx + 1'b1;
      if (last) begin
        co    <= c8;
        ovf   <= (areg[W-1] == beff[W-1]) && (sum[7] != areg[W-1]);
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_add_seq8.sv
// tb_add_seq8: directed and random checks of add_seq8 against a signed/unsigned arithmetic model.
module tb_add_seq8;
  localparam int NB = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        ci = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, co, ovf;
  logic [31:0] s;
  int tests = 0;
  int fails = 0;

  add_seq8 #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ovf, co, s} from plain signed and unsigned arithmetic
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic sb, input logic c);
    longint sr;
    longint ur;
    logic [31:0] r;
    logic cy, ov;
    if (sb) begin
      sr = longint'($signed(x)) - longint'($signed(y));
      r  = x - y;
      cy = x >= y;
    end else begin
      sr = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      ur = longint'(x) + longint'(y) + longint'(c);
      r  = x + y + 32'(c);
      cy = ur > 64'hFFFF_FFFF;
    end
    ov = sr > 64'sh7FFF_FFFF || sr < -64'sh8000_0000;
    return {ov, cy, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                    input logic cv, input bit noisy);
    logic [33:0] e;
    e = model(av, bv, sv, cv);
    @(negedge clk);
    a = av; b = bv; sub = sv; ci = cv; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_e0", busy, 1'b1);
    for (int i = 1; i < NB; i++) begin
      if (noisy) begin
        start = i[0]; a = $urandom; b = $urandom; sub = $urandom; ci = $urandom;
      end
      tick();
      chk("busy_run", {done, busy}, 2'b01);
    end
    start = 1'b0;
    tick();
    chk("done_pulse", {done, busy}, 2'b10);
    chk("result", {ovf, co, s}, e);
    tick();
    chk("done_end", {done, busy}, 2'b00);
    chk("result_held", {ovf, co, s}, e);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_state", {busy, done, ovf, co, s}, 36'd0);
    @(negedge clk); rst_n = 1'b1;
    op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 0);
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    op(32'd5, 32'd7, 1'b1, 1'b1, 0);
    op(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1);
    // back-to-back with start held high
    @(negedge clk);
    a = 32'h1; b = 32'h1; sub = 1'b0; ci = 1'b0; start = 1'b1;
    tick();
    a = 32'h10; b = 32'h20;
    repeat (NB) tick();
    chk("b2b_done1", {done, s}, {1'b1, 32'h2});
    tick();
    start = 1'b0;
    chk("b2b_rerun", {done, busy}, 2'b01);
    repeat (NB - 1) tick();
    chk("b2b_busy_last", busy, 1'b1);
    tick();
    chk("b2b_done2", {done, s}, {1'b1, 32'h30});
    // reset during the second RUN cycle
    op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 0);
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_state", {busy, done, ovf, co, s}, 36'd0);
    for (int i = 0; i < NB + 2; i++) begin
      tick();
      chk("abort_nodone", {done, busy}, 2'b00);
    end
    op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);
    // reset has priority over start
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    tick();
    chk("rst_prio", {busy, done}, 2'b00);
    rst_n = 1'b1; start = 1'b0;
    tick();
    chk("rst_prio_idle", {busy, done}, 2'b00);
    for (int i = 0; i < 24; i++)
      op($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
